// File: rtl/key_bytes_to_words_pkg.sv
// Shared types and default constants for the RC5 key byte-to-word loader.
package key_bytes_to_words_pkg;

    localparam int unsigned W        = 32;
    localparam int unsigned U        = 4;
    localparam int unsigned B        = 16;
    localparam int unsigned C        = 4;
    localparam int unsigned B_LENGTH = $clog2(B);
    localparam int unsigned C_LENGTH = $clog2(C);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        LOAD   = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/key_bytes_to_words.sv
// RC5 key byte-to-word conversion: for i = b-1 downto 0,
// L[i/u] = (L[i/u] << 8) + K[i], one byte per cycle against external stores.
// Optional macro KEY_BYTES_TO_WORDS_CLEAR_EN adds a CLEAR phase that zeroes
// L[0..c-1] before the byte loads.
module key_bytes_to_words
    import key_bytes_to_words_pkg::*;
#(
    parameter int unsigned b        = B,
    parameter int unsigned b_length = B_LENGTH,
    parameter int unsigned w        = W,
    parameter int unsigned u        = U,
    parameter int unsigned c        = C,
    parameter int unsigned c_length = C_LENGTH
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          key_sub_i,
    input  logic [w-1:0]        L_sub_i,
    output logic [b_length-1:0] key_address,
    output logic [c_length-1:0] L_address,
    output logic [w-1:0]        L_sub_i_prima,
    output logic                L_we,
    output logic                busy,
    output logic                done
);

    localparam int unsigned         SHIFT = $clog2(u);
    localparam logic [b_length-1:0] I_TOP = b_length'(b - 1);

    // Word count must cover the key exactly: c = ceil(b/u).
    if (c != (b + u - 1) / u) begin : g_bad_c
        $error("key_bytes_to_words: c must equal ceil(b/u)");
    end

    state_t              state, state_next;
    logic [b_length-1:0] i, i_next;

`ifdef KEY_BYTES_TO_WORDS_CLEAR_EN
    localparam logic [c_length-1:0] J_LAST = c_length'(c - 1);
    logic [c_length-1:0] j, j_next;

    // State, byte counter and clear counter registers.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
        end else begin
            state <= state_next;
            i     <= i_next;
            j     <= j_next;
        end
    end
`else
    // State and byte counter registers.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            i     <= '0;
        end else begin
            state <= state_next;
            i     <= i_next;
        end
    end
`endif

    // Next-state logic and all outputs, decoded from state and counters.
    always_comb begin
        state_next    = state;
        i_next        = i;
`ifdef KEY_BYTES_TO_WORDS_CLEAR_EN
        j_next        = j;
`endif
        key_address   = '0;
        L_address     = '0;
        L_sub_i_prima = '0;
        L_we          = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    i_next = I_TOP;
`ifdef KEY_BYTES_TO_WORDS_CLEAR_EN
                    j_next     = '0;
                    state_next = CLEAR;
`else
                    state_next = LOAD;
`endif
                end
            end
`ifdef KEY_BYTES_TO_WORDS_CLEAR_EN
            CLEAR: begin
                busy      = 1'b1;
                L_we      = 1'b1;
                L_address = j;
                if (j == J_LAST) begin
                    state_next = LOAD;
                end else begin
                    j_next = j + 1'b1;
                end
            end
`endif
            LOAD: begin
                busy          = 1'b1;
                L_we          = 1'b1;
                key_address   = i;
                L_address     = c_length'(i >> SHIFT);
                // Shift the word up one byte and append K[i]; top byte drops (mod 2^w).
                L_sub_i_prima = w'({L_sub_i, key_sub_i});
                if (i == '0) begin
                    state_next = FINISH;
                end else begin
                    i_next = i - 1'b1;
                end
            end
            FINISH: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_key_bytes_to_words.sv
// Self-checking bench for key_bytes_to_words with external key and L stores.
// Honours KEY_BYTES_TO_WORDS_CLEAR_EN for the expected latency and write count.
module tb_key_bytes_to_words;

    localparam int NB = 16;
    localparam int NC = 4;
`ifdef KEY_BYTES_TO_WORDS_CLEAR_EN
    localparam int          CLR     = NC;
    localparam logic [31:0] PRE_VAL = 32'hDEADBEEF;
`else
    localparam int          CLR     = 0;
    localparam logic [31:0] PRE_VAL = 32'h0;
`endif
    localparam int LAT = NB + 1 + CLR;

    logic        clk1 = 1'b0;
    logic        rst, start;
    logic [7:0]  key_sub_i;
    logic [31:0] L_sub_i;
    logic [3:0]  key_address;
    logic [1:0]  L_address;
    logic [31:0] L_sub_i_prima;
    logic        L_we, busy, done;

    logic [7:0]  kb [NB];
    logic [31:0] lmem [NC];
    logic [31:0] exp_w [NC];
    logic        preload_req;
    logic [127:0] kv;

    int checks = 0;
    int errors = 0;
    int cycles, done_cnt, done_at, we_cnt;

    key_bytes_to_words dut (
        .clk1(clk1), .rst(rst), .start(start), .key_sub_i(key_sub_i),
        .L_sub_i(L_sub_i), .key_address(key_address), .L_address(L_address),
        .L_sub_i_prima(L_sub_i_prima), .L_we(L_we), .busy(busy), .done(done)
    );

    always #5 clk1 = ~clk1;

    assign key_sub_i = kb[key_address];
    assign L_sub_i   = lmem[L_address];

    // External L store: preload on request, otherwise accept DUT writes.
    always @(posedge clk1) begin
        if (preload_req) begin
            for (int k = 0; k < NC; k++) lmem[k] <= PRE_VAL;
        end else if (L_we) begin
            lmem[L_address] <= L_sub_i_prima;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // Reference: RC5 byte-to-word rule applied to a zeroed L with 32-bit wrap.
    task automatic compute_model();
        for (int k = 0; k < NC; k++) exp_w[k] = 32'h0;
        for (int k = NB - 1; k >= 0; k--)
            exp_w[k / 4] = (exp_w[k / 4] << 8) + {24'h0, kb[k]};
    endtask

    task automatic preload();
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
    endtask

    task automatic run_conv(input bit repulse);
        preload();
        compute_model();
        start    = 1'b1;
        cycles   = 0;
        done_cnt = 0;
        done_at  = 0;
        we_cnt   = 0;
        while (cycles < LAT + 4) begin
            tick();
            cycles++;
            if (cycles == 1) begin
                start = 1'b0;
                chk("busy_after_start", {31'h0, busy}, 32'h1);
            end
            if (repulse && cycles == CLR + 3) start = 1'b1;
            if (repulse && cycles == CLR + 4) start = 1'b0;
            if (L_we) we_cnt++;
            if (done) begin
                done_cnt++;
                done_at = cycles;
            end
`ifdef KEY_BYTES_TO_WORDS_CLEAR_EN
            if (cycles <= CLR) begin
                chk("clear_addr", {30'h0, L_address}, cycles - 1);
                chk("clear_data", L_sub_i_prima, 32'h0);
                chk("clear_we", {31'h0, L_we}, 32'h1);
            end
`endif
            if (cycles == CLR + 1) begin
                chk("first_key_addr", {28'h0, key_address}, 32'd15);
                chk("first_L_addr", {30'h0, L_address}, 32'd3);
                chk("first_L_in", L_sub_i, 32'h0);
                chk("first_data", L_sub_i_prima, {24'h0, kb[15]});
                chk("first_we", {31'h0, L_we}, 32'h1);
            end
        end
        chk("done_count", done_cnt, 1);
        chk("latency", done_at, LAT);
        chk("we_count", we_cnt, NB + CLR);
        chk("busy_idle", {31'h0, busy}, 32'h0);
        for (int k = 0; k < NC; k++) chk("L_word", lmem[k], exp_w[k]);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_key_addr"}, {28'h0, key_address}, 32'h0);
        chk({tag, "_L_addr"}, {30'h0, L_address}, 32'h0);
        chk({tag, "_data"}, L_sub_i_prima, 32'h0);
        chk({tag, "_we"}, {31'h0, L_we}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_done"}, {31'h0, done}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        preload_req = 1'b0;
        for (int k = 0; k < NB; k++) kb[k] = 8'h0;
        #1;
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_all_zero("idle");

        // Reference key with known result words.
        kv = 128'hFFFEEEE58684FFF05FFE493853000434;
        for (int k = 0; k < NB; k++) kb[k] = kv[8*k +: 8];
        run_conv(1'b0);
        chk("ref_L0", lmem[0], 32'h53000434);
        chk("ref_L1", lmem[1], 32'h5FFE4938);
        chk("ref_L2", lmem[2], 32'h8684FFF0);
        chk("ref_L3", lmem[3], 32'hFFFEEEE5);

        // Second start during LOAD must be ignored.
        for (int k = 0; k < NB; k++) kb[k] = 8'($urandom);
        run_conv(1'b1);

        // Reset on the 5th LOAD cycle aborts without done.
        preload();
        start = 1'b1;
        done_cnt = 0;
        for (int n = 1; n <= CLR + 5; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (done) done_cnt++;
        end
        chk("abort_pre_key_addr", {28'h0, key_address}, 32'd11);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        tick();
        rst = 1'b0;
        for (int n = 0; n < NB + CLR + 4; n++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle_busy", {31'h0, busy}, 32'h0);
        run_conv(1'b0);

        // All-zero and all-FF keys.
        for (int k = 0; k < NB; k++) kb[k] = 8'h00;
        run_conv(1'b0);
        for (int k = 0; k < NC; k++) chk("zero_key_L", lmem[k], 32'h0);
        for (int k = 0; k < NB; k++) kb[k] = 8'hFF;
        run_conv(1'b0);
        for (int k = 0; k < NC; k++) chk("ff_key_L", lmem[k], 32'hFFFFFFFF);

        // Random keys.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NB; k++) kb[k] = 8'($urandom);
            run_conv(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
